// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the 5- and 10-unit sensor lines,
// turns rising filtered edges into one-cycle coin codes, and applies a post-coin lockout.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic [1:0] coin_code,
  output logic       reject,
  output logic [7:0] coin_count
);

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LOCK_INIT = 8'(LOCKOUT_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [1:0] raw_w;
  logic [1:0] event_w;

  assign raw_w = {coin10_raw, coin5_raw};

  // Bit 0 is the 5-unit channel, bit 1 the 10-unit channel, matching the coin code.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_prev_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        filt_q      <= 1'b0;
        filt_prev_q <= 1'b0;
        cnt_q       <= 4'd0;
      end else begin
        sync1_q     <= raw_w[gi];
        sync2_q     <= sync1_q;
        filt_prev_q <= filt_q;
        if (sync2_q == filt_q) begin
          cnt_q <= 4'd0;
        end else if (cnt_q == DB_LAST) begin
          filt_q <= sync2_q;
          cnt_q  <= 4'd0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end

    assign event_w[gi] = filt_q & ~filt_prev_q;
  end

  logic [0:0] state_q, state_d;
  logic [7:0] lock_q, lock_d;
  logic [1:0] code_q, code_d;
  logic       reject_q, reject_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    code_d   = 2'b00;
    reject_d = 1'b0;
    count_d  = count_q;
    if (state_q == ST_IDLE) begin
      if (event_w == 2'b11) begin
        reject_d = 1'b1;
        lock_d   = LOCK_INIT;
        state_d  = ST_LOCK;
      end else if (event_w != 2'b00) begin
        code_d = event_w;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        lock_d  = LOCK_INIT;
        state_d = ST_LOCK;
      end
    end else begin
      // Rejects during lockout do not extend the dead time.
      reject_d = |event_w;
      lock_d   = lock_q - 8'd1;
      if (lock_q == 8'd1) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lock_q   <= 8'd0;
      code_q   <= 2'b00;
      reject_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      code_q   <= code_d;
      reject_q <= reject_d;
      count_q  <= count_d;
    end
  end

  assign coin_code  = code_q;
  assign reject     = reject_q;
  assign coin_count = count_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor that sits directly upstream of the vending machine FSM. It converts two raw, asynchronous, bouncy coin-sensor lines (5-unit and 10-unit) into the clean 2-bit coin code the vending machine samples every cycle. It synchronizes and debounces each line, detects one coin per insertion, rejects colliding or too-close insertions, and keeps a saturating count of accepted coins.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a filtered level changes (legal range 1–15).
- `LOCKOUT_CYCLES`, default 8: dead time after any accept or collision-reject (legal range 1–255).
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `coin5_raw` input 1: raw 5-unit sensor, asynchronous to `clk`, may bounce.
- `coin10_raw` input 1: raw 10-unit sensor, asynchronous to `clk`, may bounce.
- `coin_code` output 2: one-cycle coin event. 00 = none, 01 = 5, 10 = 10. 11 is never driven. Connects to the vending machine `in`.
- `reject` output 1: one-cycle pulse when a detected coin is refused.
- `coin_count` output 8: accepted coins since reset, saturates at 255.

## Operation
- **Synchronizer.** Two-flop synchronizer per raw line; all flops reset to 0.
- **Debounce.** One counter and one filtered level per channel.
  - The counter increments each cycle the synchronized value differs from the filtered level.
  - It clears to 0 whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the filtered level takes the synchronized value and the counter clears.
- **Event.** An event is a 0→1 transition of a filtered level.
  - Falling transitions have no effect.
  - A line held high produces exactly one event.
- **FSM states.** IDLE and LOCKOUT; reset state is IDLE.
- **IDLE, exactly one channel event:**
  - `coin_code` is driven to that channel's code on the next edge, for one cycle.
  - `coin_count` increments, saturating at 255.
  - The lockout counter loads `LOCKOUT_CYCLES` and the FSM goes to LOCKOUT.
- **IDLE, both channels' events in the same cycle:**
  - `reject` is driven to 1 on the next edge, for one cycle; `coin_code` stays 00.
  - The count is unchanged.
  - The lockout counter loads and the FSM goes to LOCKOUT.
- **LOCKOUT:**
  - The lockout counter decrements each cycle; the FSM returns to IDLE on the edge where it reaches 0.
  - Any event (either channel) pulses `reject` for one cycle.
  - `coin_code` stays 00.
  - The lockout counter is not reloaded.
- **Registered outputs.** All outputs are registered; no combinational path from inputs to outputs.
- **Reset.** Asserting `rst` at any time, including mid-debounce or mid-lockout, asynchronously clears:
  - synchronizers, debounce counters and filtered levels;
  - the lockout counter, and returns the FSM to IDLE;
  - `coin_code`=00, `reject`=0, `coin_count`=0.
- **Line high at reset release.** A raw line high at reset release is treated as a new insertion. It produces one event after the normal latency.

## Timing
- **Reset values:** `coin_code`=00, `reject`=0, `coin_count`=0.
- **Latency.** Let N be the first rising edge sampling a raw line high, with the line stable afterwards.
  - The synchronized value is high after edge N+1.
  - The filtered level rises on edge N+1+`DEBOUNCE_CYCLES`.
  - `coin_code` (or `reject`) is asserted from edge N+2+`DEBOUNCE_CYCLES` for exactly one cycle.
  - With defaults, that is 6 cycles after N.
- **Glitch rejection.** A raw pulse shorter than `DEBOUNCE_CYCLES` cycles after synchronization produces no event.
- **`coin_count`** updates on the same edge that asserts `coin_code`.
- **Re-acceptance window.** If a pulse is asserted on edge E, the next accept is possible no earlier than edge E+`LOCKOUT_CYCLES`+1. The FSM is back in IDLE after edge E+`LOCKOUT_CYCLES`.
- **Collision in IDLE.** Events on both channels in the same IDLE cycle are a collision; neither coin is accepted.
- **Event at the lockout boundary.** An event in the cycle the FSM returns to IDLE is evaluated as IDLE and is accepted.
- **`reject`** is never asserted in the same cycle as a nonzero `coin_code`.

## Test plan
All scenarios use defaults (`DEBOUNCE_CYCLES`=4, `LOCKOUT_CYCLES`=8).
- **Reset:** `rst`=1 with raw inputs toggling → `coin_code`=00, `reject`=0, `coin_count`=0 throughout. Deassert `rst`; the first pulse appears only after a raw high line completes debounce.
- **Clean nickel:** `coin5_raw` high for 12 cycles from edge N → `coin_code`=01 only in the cycle after edge N+6, `coin_count`=1. No second pulse on release.
- **Bounce/glitch:**
  - `coin10_raw` high 3 cycles, low 2, high 3 → no `coin_code`, no `reject`, count 0.
  - Then hold it high 10 cycles → `coin_code`=10 once, count 1.
- **Lockout:**
  - Dime accepted at edge E.
  - Nickel whose event lands at E+4 → `reject`=1 for one cycle, `coin_code`=00, count unchanged.
  - A nickel event at E+9 → `coin_code`=01, count +1.
- **Collision:** both raw lines rise on the same edge and stay high → single `reject` pulse at N+6, `coin_code` stays 00, count unchanged, LOCKOUT entered.
- **Saturation and mid-operation reset:**
  - 260 spaced valid coins → `coin_count` stops at 255 while `coin_code` pulses still occur.
  - Assert `rst` during a debounce in progress → all outputs 0 immediately, no stale pulse after release.
